// File: rtl/motor_register_bank.sv
// ---------------------------------------------------------------------------
// motor_register_bank: Avalon-MM shadow/active parameter bank with snapshot
// telemetry for the motor comms engine.                           Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module motor_register_bank #(
  parameter int          NUMBER_OF_MOTORS       = 8,
  parameter logic [31:0] ID_VALUE               = 32'hB15B00B5,
  parameter int          DEFAULT_PWM_LIMIT      = 8388607,
  parameter int          DEFAULT_INTEGRAL_LIMIT = 500000,
  parameter int          DEFAULT_GEARBOX_RATIO  = 53
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [15:0]                     address,
  input  logic                            write,
  input  logic signed [31:0]              writedata,
  input  logic                            read,
  output logic [31:0]                     readdata,
  output logic                            waitrequest,
  output logic [8*NUMBER_OF_MOTORS-1:0]   Kp_o,
  output logic [8*NUMBER_OF_MOTORS-1:0]   Ki_o,
  output logic [8*NUMBER_OF_MOTORS-1:0]   Kd_o,
  output logic [24*NUMBER_OF_MOTORS-1:0]  sp_o,
  output logic [24*NUMBER_OF_MOTORS-1:0]  PWMLimit_o,
  output logic [24*NUMBER_OF_MOTORS-1:0]  IntegralLimit_o,
  output logic [24*NUMBER_OF_MOTORS-1:0]  deadband_o,
  output logic [24*NUMBER_OF_MOTORS-1:0]  gearboxRatio_o,
  output logic [8*NUMBER_OF_MOTORS-1:0]   control_mode_o,
  output logic [31:0]                     update_frequency_Hz_o,
  input  logic [24*NUMBER_OF_MOTORS-1:0]  encoder0_i,
  input  logic [24*NUMBER_OF_MOTORS-1:0]  encoder1_i,
  input  logic [24*NUMBER_OF_MOTORS-1:0]  displacement_i,
  input  logic [24*NUMBER_OF_MOTORS-1:0]  duty_i,
  input  logic [32*NUMBER_OF_MOTORS-1:0]  error_code_i
);
  localparam int         c_NM     = NUMBER_OF_MOTORS;
  localparam logic [7:0] c_ID     = 8'h00, c_KP = 8'h01, c_KI = 8'h02, c_KD = 8'h03;
  localparam logic [7:0] c_ENC0   = 8'h04, c_ENC1 = 8'h05, c_PWM = 8'h08, c_IL = 8'h09;
  localparam logic [7:0] c_DB     = 8'h0A, c_CM = 8'h0B, c_SP = 8'h0C, c_ERR = 8'h0D;
  localparam logic [7:0] c_FREQ   = 8'h11, c_GB = 8'h12, c_DUTY = 8'h17, c_DISP = 8'h18;
  localparam logic [7:0] c_COMMIT = 8'h20, c_PEND = 8'h21, c_SNAP = 8'h22, c_SCNT = 8'h23;

  typedef enum logic [0:0] {S_IDLE, S_ACK} state_t;

  state_t      state_q;
  logic [31:0] readdata_q, rdata_d;
  logic [7:0]  kp_sh_q [c_NM], ki_sh_q [c_NM], kd_sh_q [c_NM], cm_sh_q [c_NM];
  logic [7:0]  kp_act_q[c_NM], ki_act_q[c_NM], kd_act_q[c_NM], cm_act_q[c_NM];
  logic [23:0] pwm_sh_q [c_NM], il_sh_q [c_NM], db_sh_q [c_NM], gb_sh_q [c_NM];
  logic [23:0] pwm_act_q[c_NM], il_act_q[c_NM], db_act_q[c_NM], gb_act_q[c_NM];
  logic [23:0] sp_q[c_NM];
  logic [23:0] enc0_snap_q[c_NM], enc1_snap_q[c_NM], disp_snap_q[c_NM], duty_snap_q[c_NM];
  logic [31:0] err_snap_q[c_NM];
  logic [c_NM-1:0] pending_q;
  logic [31:0] freq_q, snap_cnt_q;

  logic [7:0] w_sel, w_idx;
  logic       w_wr_en;

  assign w_sel       = address[15:8];
  assign w_idx       = address[7:0];
  assign waitrequest = read && (state_q == S_IDLE);
  assign w_wr_en     = write && !read && !waitrequest;
  assign readdata    = readdata_q;

  function automatic logic [7:0] sat8(input logic signed [31:0] v);
    if (v > 32'sd127)       return 8'h7F;
    else if (v < -32'sd128) return 8'h80;
    else                    return v[7:0];
  endfunction

  function automatic logic [23:0] sat24(input logic signed [31:0] v);
    if (v > 32'sd8388607)       return 24'h7FFFFF;
    else if (v < -32'sd8388608) return 24'h800000;
    else                        return v[23:0];
  endfunction

  function automatic logic [31:0] sx8(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

  function automatic logic [31:0] sx24(input logic [23:0] v);
    return {{8{v[23]}}, v};
  endfunction

  // Global registers ignore the motor field; per-motor ones need a valid index.
  always_comb begin
    rdata_d = 32'hDEADBEEF;
    case (w_sel)
      c_ID:    rdata_d = ID_VALUE;
      c_FREQ:  rdata_d = freq_q;
      c_PEND:  rdata_d = 32'(pending_q);
      c_SCNT:  rdata_d = snap_cnt_q;
      default: begin
        for (int m = 0; m < c_NM; m++) begin
          if (w_idx == 8'(m)) begin
            case (w_sel)
              c_KP:    rdata_d = sx8(kp_sh_q[m]);
              c_KI:    rdata_d = sx8(ki_sh_q[m]);
              c_KD:    rdata_d = sx8(kd_sh_q[m]);
              c_CM:    rdata_d = {24'd0, cm_sh_q[m]};
              c_PWM:   rdata_d = sx24(pwm_sh_q[m]);
              c_IL:    rdata_d = sx24(il_sh_q[m]);
              c_DB:    rdata_d = sx24(db_sh_q[m]);
              c_GB:    rdata_d = sx24(gb_sh_q[m]);
              c_SP:    rdata_d = sx24(sp_q[m]);
              c_ENC0:  rdata_d = sx24(enc0_snap_q[m]);
              c_ENC1:  rdata_d = sx24(enc1_snap_q[m]);
              c_DISP:  rdata_d = sx24(disp_snap_q[m]);
              c_DUTY:  rdata_d = sx24(duty_snap_q[m]);
              c_ERR:   rdata_d = err_snap_q[m];
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      readdata_q <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: if (read) begin
          readdata_q <= rdata_d;
          state_q    <= S_ACK;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int m = 0; m < c_NM; m++) begin
        kp_sh_q[m]  <= 8'd1;   kp_act_q[m]  <= 8'd1;
        ki_sh_q[m]  <= 8'd0;   ki_act_q[m]  <= 8'd0;
        kd_sh_q[m]  <= 8'd0;   kd_act_q[m]  <= 8'd0;
        cm_sh_q[m]  <= 8'd3;   cm_act_q[m]  <= 8'd3;
        pwm_sh_q[m] <= 24'(DEFAULT_PWM_LIMIT);      pwm_act_q[m] <= 24'(DEFAULT_PWM_LIMIT);
        il_sh_q[m]  <= 24'(DEFAULT_INTEGRAL_LIMIT); il_act_q[m]  <= 24'(DEFAULT_INTEGRAL_LIMIT);
        gb_sh_q[m]  <= 24'(DEFAULT_GEARBOX_RATIO);  gb_act_q[m]  <= 24'(DEFAULT_GEARBOX_RATIO);
        db_sh_q[m]  <= 24'd0;  db_act_q[m]  <= 24'd0;
        sp_q[m]        <= 24'd0;
        enc0_snap_q[m] <= 24'd0;
        enc1_snap_q[m] <= 24'd0;
        disp_snap_q[m] <= 24'd0;
        duty_snap_q[m] <= 24'd0;
        err_snap_q[m]  <= 32'd0;
      end
      pending_q  <= '0;
      freq_q     <= 32'd100;
      snap_cnt_q <= 32'd0;
    end else if (w_wr_en) begin
      for (int m = 0; m < c_NM; m++) begin
        if (w_idx == 8'(m)) begin
          case (w_sel)
            c_KP:    begin kp_sh_q[m]  <= sat8(writedata);  pending_q[m] <= 1'b1; end
            c_KI:    begin ki_sh_q[m]  <= sat8(writedata);  pending_q[m] <= 1'b1; end
            c_KD:    begin kd_sh_q[m]  <= sat8(writedata);  pending_q[m] <= 1'b1; end
            c_CM:    begin cm_sh_q[m]  <= writedata[7:0];   pending_q[m] <= 1'b1; end
            c_PWM:   begin pwm_sh_q[m] <= sat24(writedata); pending_q[m] <= 1'b1; end
            c_IL:    begin il_sh_q[m]  <= sat24(writedata); pending_q[m] <= 1'b1; end
            c_DB:    begin db_sh_q[m]  <= sat24(writedata); pending_q[m] <= 1'b1; end
            c_GB:    begin gb_sh_q[m]  <= sat24(writedata); pending_q[m] <= 1'b1; end
            c_SP:    sp_q[m] <= sat24(writedata);
            default: ;
          endcase
        end
        // Commit copies unconditionally, even when nothing is pending.
        if (w_sel == c_COMMIT && (w_idx == 8'(m) || w_idx == 8'hFF)) begin
          kp_act_q[m]  <= kp_sh_q[m];
          ki_act_q[m]  <= ki_sh_q[m];
          kd_act_q[m]  <= kd_sh_q[m];
          cm_act_q[m]  <= cm_sh_q[m];
          pwm_act_q[m] <= pwm_sh_q[m];
          il_act_q[m]  <= il_sh_q[m];
          db_act_q[m]  <= db_sh_q[m];
          gb_act_q[m]  <= gb_sh_q[m];
          pending_q[m] <= 1'b0;
        end
        if (w_sel == c_SNAP) begin
          enc0_snap_q[m] <= encoder0_i[24*m +: 24];
          enc1_snap_q[m] <= encoder1_i[24*m +: 24];
          disp_snap_q[m] <= displacement_i[24*m +: 24];
          duty_snap_q[m] <= duty_i[24*m +: 24];
          err_snap_q[m]  <= error_code_i[32*m +: 32];
        end
      end
      if (w_sel == c_FREQ) freq_q <= (writedata == 32'sd0) ? 32'd1 : writedata;
      if (w_sel == c_SNAP) snap_cnt_q <= snap_cnt_q + 32'd1;
    end
  end

  for (genvar m = 0; m < c_NM; m++) begin : g_out
    assign Kp_o[8*m +: 8]             = kp_act_q[m];
    assign Ki_o[8*m +: 8]             = ki_act_q[m];
    assign Kd_o[8*m +: 8]             = kd_act_q[m];
    assign control_mode_o[8*m +: 8]   = cm_act_q[m];
    assign sp_o[24*m +: 24]           = sp_q[m];
    assign PWMLimit_o[24*m +: 24]     = pwm_act_q[m];
    assign IntegralLimit_o[24*m +: 24] = il_act_q[m];
    assign deadband_o[24*m +: 24]     = db_act_q[m];
    assign gearboxRatio_o[24*m +: 24] = gb_act_q[m];
  end

  assign update_frequency_Hz_o = freq_q;

endmodule

`default_nettype wire

// File: tb/tb_motor_register_bank.sv
// ---------------------------------------------------------------------------
// tb_motor_register_bank: scoreboard bench for motor_register_bank.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_motor_register_bank;
  localparam int c_NM = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [15:0]        address = '0;
  logic               write = 1'b0;
  logic signed [31:0] writedata = '0;
  logic               read = 1'b0;
  logic [31:0]        readdata;
  logic               waitrequest;
  logic [8*c_NM-1:0]  Kp_o, Ki_o, Kd_o, control_mode_o;
  logic [24*c_NM-1:0] sp_o, PWMLimit_o, IntegralLimit_o, deadband_o, gearboxRatio_o;
  logic [31:0]        update_frequency_Hz_o;
  logic [24*c_NM-1:0] encoder0_i = '0, encoder1_i = '0, displacement_i = '0, duty_i = '0;
  logic [32*c_NM-1:0] error_code_i = '0;

  int n_tests = 0;
  int n_fail  = 0;
  int last_stalls = 0;
  logic [31:0] exp_q[$];
  string       name_q[$];

  motor_register_bank #(.NUMBER_OF_MOTORS(c_NM)) dut (
    .clk(clk), .reset(reset), .address(address), .write(write),
    .writedata(writedata), .read(read), .readdata(readdata),
    .waitrequest(waitrequest), .Kp_o(Kp_o), .Ki_o(Ki_o), .Kd_o(Kd_o),
    .sp_o(sp_o), .PWMLimit_o(PWMLimit_o), .IntegralLimit_o(IntegralLimit_o),
    .deadband_o(deadband_o), .gearboxRatio_o(gearboxRatio_o),
    .control_mode_o(control_mode_o), .update_frequency_Hz_o(update_frequency_Hz_o),
    .encoder0_i(encoder0_i), .encoder1_i(encoder1_i), .displacement_i(displacement_i),
    .duty_i(duty_i), .error_code_i(error_code_i)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (read && !waitrequest) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected read completion: readdata %h, no expectation queued", readdata);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        automatic string nm = name_q.pop_front();
        if (readdata !== e) begin
          n_fail++;
          $display("FAIL %s: readdata %h expected %h", nm, readdata, e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1;
    @(posedge clk); #1;
    write = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] a, input logic [31:0] e, input string nm);
    int stalls = 0;
    exp_q.push_back(e);
    name_q.push_back(nm);
    address = a; read = 1'b1;
    @(negedge clk);
    while (waitrequest && stalls < 8) begin
      stalls++;
      @(negedge clk);
    end
    last_stalls = stalls;
    if (stalls >= 8) begin
      n_tests++; n_fail++;
      $display("FAIL %s: waitrequest stuck, stalls %0d limit 8", nm, stalls);
    end
    @(posedge clk); #1;
    read = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;

    chk("reset readdata", 64'(readdata), 64'd0);
    chk("reset waitrequest", 64'(waitrequest), 64'd0);
    chk("reset control_mode", control_mode_o, 64'h0303_0303_0303_0303);
    chk("reset Kp_o", Kp_o, 64'h0101_0101_0101_0101);
    chk("reset freq", 64'(update_frequency_Hz_o), 64'd100);

    do_read(16'h0000, 32'hB15B00B5, "id");
    chk("id stalls", 64'(last_stalls), 64'd1);
    do_read(16'h0103, 32'd1, "kp3 reset");
    do_read(16'h2100, 32'd0, "pending reset");
    do_read(16'h2300, 32'd0, "snapcnt reset");
    do_read(16'h0800, 32'd8388607, "pwm reset");

    // Shadow write then commit
    do_write(16'h0102, 32'd50);
    do_read(16'h2100, 32'h4, "pending kp2");
    chk("Kp_o[2] before commit", 64'(Kp_o[16 +: 8]), 64'h01);
    do_read(16'h0102, 32'd50, "kp2 shadow");
    do_write(16'h2002, 32'd0);
    chk("Kp_o[2] after commit", 64'(Kp_o[16 +: 8]), 64'd50);
    do_read(16'h2100, 32'd0, "pending after commit");

    // Saturation
    do_write(16'h0100, 32'd300);
    do_read(16'h0100, 32'd127, "kp0 sat high");
    do_write(16'h0101, -32'sd300);
    do_read(16'h0101, 32'hFFFFFF80, "kp1 sat low");
    do_write(16'h0800, -32'sd9000000);
    do_read(16'h0800, 32'hFF800000, "pwm sat low");
    do_write(16'h1100, 32'd0);
    do_read(16'h1100, 32'd1, "freq zero");
    do_write(16'h1105, 32'd5000);
    do_read(16'h1100, 32'd5000, "freq index ignored");
    chk("freq output", 64'(update_frequency_Hz_o), 64'd5000);

    // Snapshot coherence
    encoder0_i[24 +: 24]     = 24'd1000;
    displacement_i[0 +: 24]  = 24'hFFFFFE;
    error_code_i[224 +: 32]  = 32'hCAFEF00D;
    do_write(16'h2200, 32'd0);
    encoder0_i[24 +: 24]     = 24'd2000;
    do_read(16'h0401, 32'd1000, "snap enc0[1]");
    do_read(16'h2300, 32'd1, "snapcnt one");
    do_read(16'h1800, 32'hFFFFFFFE, "snap disp[0] sign");
    do_read(16'h0D07, 32'hCAFEF00D, "snap err[7]");

    // Range and illegal addresses
    do_read(16'h0109, 32'hDEADBEEF, "kp idx 9");
    do_write(16'h0109, 32'd77);
    chk("Kp_o after illegal write", Kp_o, 64'h0101_0101_0132_0101);
    do_read(16'h0700, 32'hDEADBEEF, "unmapped reg");
    do_read(16'h2100, 32'h3, "pending kp0/kp1/pwm0");

    // Commit-all and immediate sp
    do_write(16'h0200, 32'd11);
    do_write(16'h0207, -32'sd7);
    do_write(16'h20FF, 32'd0);
    chk("Ki_o[0] commit all", 64'(Ki_o[0 +: 8]), 64'd11);
    chk("Ki_o[7] commit all", 64'(Ki_o[56 +: 8]), 64'hF9);
    chk("Kp_o after commit all", Kp_o, 64'h0101_0101_0132_807F);
    chk("PWMLimit_o[0] commit", 64'(PWMLimit_o[0 +: 24]), 64'h800000);
    do_read(16'h2100, 32'd0, "pending after commit all");
    do_write(16'h0C03, -32'sd5);
    chk("sp_o[3] immediate", 64'(sp_o[72 +: 24]), 64'hFFFFFB);
    do_read(16'h0C03, 32'hFFFFFFFB, "sp3 readback");

    // A write overlapping a read is ignored
    write = 1'b1; writedata = 32'd9;
    do_read(16'h0104, 32'd1, "kp4 during write+read");
    write = 1'b0;
    do_read(16'h0104, 32'd1, "kp4 unchanged");

    // Reset while a read is stalled
    address = 16'h0000; read = 1'b1; reset = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("reset mid-read waitrequest", 64'(waitrequest), 64'd1);
    chk("reset mid-read readdata", 64'(readdata), 64'd0);
    chk("reset mid-read Kp_o", Kp_o, 64'h0101_0101_0101_0101);
    chk("reset mid-read freq", 64'(update_frequency_Hz_o), 64'd100);
    chk("reset mid-read sp_o[3]", 64'(sp_o[72 +: 24]), 64'd0);
    @(posedge clk); #1;
    read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    do_read(16'h2300, 32'd0, "snapcnt after reset");
    do_read(16'h0401, 32'd0, "snap enc0 after reset");

    repeat (2) @(posedge clk);
    chk("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
